// File: rtl/mb32_pkg.sv
// rtl/mb32_pkg.sv - shared constants, FSM state type and mask helper for mb32_spram
// Purpose: bus geometry, SPRAM macro geometry and the responder state enum.
// Ports: none (package).
package mb32_pkg;

  localparam int DSZ      = 32;
  localparam int ASZ      = 20 - $clog2(DSZ);
  localparam int SPRAM_AW = 14;
  localparam int BANK_BIT = 14;

  typedef enum logic {
    ST_CLR,
    ST_RUN
  } mb32_st_e;

  // One byte-lane enable covers two nibbles of a 16-bit macro.
  function automatic logic [3:0] nib_mask(input logic [1:0] b);
    return {b[1], b[1], b[0], b[0]};
  endfunction

endpackage

// File: rtl/spram_16k16.sv
// rtl/spram_16k16.sv - one 16K x 16 single-port RAM macro with nibble write mask
// Purpose: behavioural stand-in for the vendor SPRAM primitive.
// Ports:
//   clk     in   clock, rising edge
//   i_cs    in   chip select; nothing happens when low (output holds)
//   i_we    in   write enable (with i_cs)
//   i_addr  in   14-bit word address
//   i_din   in   16-bit write data
//   i_mask  in   per-nibble write enables, bit n covers i_din[4n+3:4n]
//   o_dout  out  registered read data; undefined after a write cycle
module spram_16k16
  import mb32_pkg::*;
(
  input  logic                clk,
  input  logic                i_cs,
  input  logic                i_we,
  input  logic [SPRAM_AW-1:0] i_addr,
  input  logic [15:0]         i_din,
  input  logic [3:0]          i_mask,
  output logic [15:0]         o_dout
);

  logic [15:0] r_mem [0:(1<<SPRAM_AW)-1];
  logic [15:0] r_dout;

  // The real macro drives garbage on its output during a write; model that
  // with 'x so nothing upstream can silently depend on it.
  always_ff @(posedge clk) begin
    if (i_cs) begin
      if (i_we) begin
        for (int n = 0; n < 4; n++) begin
          if (i_mask[n]) begin
            r_mem[i_addr][4*n +: 4] <= i_din[4*n +: 4];
          end
        end
        r_dout <= 'x;
      end else begin
        r_dout <= r_mem[i_addr];
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/mb32_spram.sv
// rtl/mb32_spram.sv - 32-bit memory bus responder backed by four 16K x 16 SPRAMs
// Purpose: serves we/ai/vi/bmsk requests with 1-cycle read latency, zero-fills
//          (CLR_VAL-fills) the whole 128 KB after reset while busy is high.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   we     in   write strobe
//   ai     in   word address (ai[14] = bank pair, ai[13:0] = macro address)
//   vi     in   write data
//   bmsk   in   byte-lane write enables
//   vo     out  read data (held across write cycles, 0 while busy)
//   busy   out  clear in progress, bus ignored
module mb32_spram #(
  parameter int                   DSZ      = mb32_pkg::DSZ,
  parameter int                   ASZ      = mb32_pkg::ASZ,
  parameter bit                   INIT_CLR = 1'b1,
  parameter logic [DSZ-1:0]       CLR_VAL  = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [ASZ-1:0] ai,
  input  logic [DSZ-1:0] vi,
  input  logic [3:0]     bmsk,
  output logic [DSZ-1:0] vo,
  output logic           busy
);

  import mb32_pkg::*;

  mb32_st_e            r_state;
  mb32_st_e            w_state_nxt;
  logic [SPRAM_AW-1:0] r_cnt;
  logic [SPRAM_AW-1:0] w_cnt_nxt;
  logic                r_sel_q;
  logic                r_rd_q;
  logic [DSZ-1:0]      r_vo_q;

  logic                w_busy;
  logic                w_clr;
  logic                w_rd;
  logic                w_wr;
  logic                w_sel;
  logic [1:0]          w_cs;
  logic [1:0]          w_we;
  logic [SPRAM_AW-1:0] w_addr;
  logic [DSZ-1:0]      w_din;
  logic [7:0]          w_mask;
  logic [15:0]         w_lo_q [2];
  logic [15:0]         w_hi_q [2];
  logic [DSZ-1:0]      w_rdata;

  // State, clear counter and read-return tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT_CLR ? ST_CLR : ST_RUN;
      r_cnt   <= '0;
      r_sel_q <= 1'b0;
      r_rd_q  <= 1'b0;
      r_vo_q  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd_q  <= w_rd;
      if (w_rd) begin
        r_sel_q <= w_sel;
      end
      if (r_rd_q) begin
        r_vo_q <= w_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_CLR: begin
        w_busy    = 1'b1;
        w_clr     = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_sel  = ai[BANK_BIT];
  assign w_rd   = !w_busy && !we;
  assign w_wr   = !w_busy && we;
  assign w_addr = w_clr ? r_cnt : ai[SPRAM_AW-1:0];
  assign w_din  = w_clr ? CLR_VAL : vi;
  assign w_mask = w_clr ? 8'hFF : {nib_mask(bmsk[3:2]), nib_mask(bmsk[1:0])};

  // Reads enable both pairs; the registered bank select picks the result.
  // A write only touches the addressed pair so the other keeps its output.
  for (genvar p = 0; p < 2; p++) begin : g_pair
    assign w_cs[p] = w_clr || w_rd || (w_wr && (w_sel == 1'(p)));
    assign w_we[p] = w_clr || (w_wr && (w_sel == 1'(p)));

    spram_16k16 u_lo (
      .clk    (clk),
      .i_cs   (w_cs[p]),
      .i_we   (w_we[p]),
      .i_addr (w_addr),
      .i_din  (w_din[15:0]),
      .i_mask (w_mask[3:0]),
      .o_dout (w_lo_q[p])
    );

    spram_16k16 u_hi (
      .clk    (clk),
      .i_cs   (w_cs[p]),
      .i_we   (w_we[p]),
      .i_addr (w_addr),
      .i_din  (w_din[31:16]),
      .i_mask (w_mask[7:4]),
      .o_dout (w_hi_q[p])
    );
  end

  assign w_rdata = r_sel_q ? {w_hi_q[1], w_lo_q[1]} : {w_hi_q[0], w_lo_q[0]};

  // Only expose macro output in the cycle right after a read; after a write
  // (or clear) the macros hold undefined data, so replay the last read.
  assign vo   = w_busy ? '0 : (r_rd_q ? w_rdata : r_vo_q);
  assign busy = w_busy;

endmodule
